// File: rtl/mem_bus_xbar_pkg.sv
// Shared definitions for the native-bus crossbar: FSM encodings, default error
// read data and the standard memory map.
package mem_bus_xbar_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_ERR    = 2'd2,
        ST_DONE   = 2'd3
    } xbar_state_t;

    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

    localparam logic [31:0] FLASH_BASE   = 32'h0000_0000;
    localparam logic [31:0] FLASH_MASK   = 32'hFFFE_0000;
    localparam logic [31:0] SRAM_BASE    = 32'h0002_0000;
    localparam logic [31:0] SRAM_MASK    = 32'hFFFF_E000;
    localparam logic [31:0] LED_BASE     = 32'h8000_0000;
    localparam logic [31:0] LED_MASK     = 32'hFFFF_FFFF;
    localparam logic [31:0] SYSTICK_BASE = 32'h8000_0100;
    localparam logic [31:0] SYSTICK_MASK = 32'hFFFF_FFF0;

endpackage

// File: rtl/mem_bus_xbar_if.sv
// Native valid/ready memory bus: master side towards the cpu, N select lines
// and shared request fields towards the slaves.
interface mem_bus_xbar_if #(
    parameter int N_SLAVES = 4
);
    logic                   m_valid;
    logic [31:0]            m_addr;
    logic [31:0]            m_wdata;
    logic [3:0]             m_wstrb;
    logic                   m_ready;
    logic [31:0]            m_rdata;
    logic [N_SLAVES-1:0]    s_sel;
    logic [31:0]            s_addr;
    logic [31:0]            s_wdata;
    logic [3:0]             s_wstrb;
    logic [N_SLAVES-1:0]    s_ready;
    logic [N_SLAVES*32-1:0] s_rdata;

    modport master (
        output m_valid, m_addr, m_wdata, m_wstrb,
        input  m_ready, m_rdata
    );

    modport slave (
        input  s_sel, s_addr, s_wdata, s_wstrb,
        output s_ready, s_rdata
    );

    modport xbar (
        input  m_valid, m_addr, m_wdata, m_wstrb, s_ready, s_rdata,
        output m_ready, m_rdata, s_sel, s_addr, s_wdata, s_wstrb
    );
endinterface

// File: rtl/mem_bus_timeout.sv
// Bus-timeout counter: cleared while idle, counts active cycles and holds at
// the limit so the expired flag stays up until the next clear.
module mem_bus_timeout #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT_CYCLES + 1);

    logic [W-1:0] count;

    assign expired = (count == W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + W'(1);
        end
    end
endmodule

// File: rtl/mem_bus_xbar.sv
// Table-driven 1-master/N-slave decoder for the picorv32 native bus with
// registered decode, timeout and unmapped-address error reporting.
//
//  state  | meaning
//  IDLE   | waiting for m_valid; decode address, latch one-hot slave
//  ACTIVE | selected slave sees s_sel; wait for its s_ready or timeout
//  ERR    | unmapped or timed-out access: complete with ERR_RDATA, raise irq
//  DONE   | one dead cycle so a re-issued request is not double-counted
module mem_bus_xbar
    import mem_bus_xbar_pkg::*;
#(
    parameter int                     N_SLAVES       = 4,
    parameter logic [N_SLAVES*32-1:0] SLAVE_BASE     = {N_SLAVES{32'h0}},
    parameter logic [N_SLAVES*32-1:0] SLAVE_MASK     = {N_SLAVES{32'hFFFF_FFFF}},
    parameter int                     TIMEOUT_CYCLES = 255,
    parameter logic [31:0]            ERR_RDATA      = ERR_RDATA_DEFAULT
) (
    input  logic         clk,
    input  logic         reset_n,
    mem_bus_xbar_if.xbar bus,
    output logic         err_irq,
    output logic [31:0]  err_addr,
    output logic [7:0]   err_count
);
    xbar_state_t         state_q, state_d;
    logic [N_SLAVES-1:0] hit, onehot, sel_q, sel_d;
    logic [N_SLAVES:0]   lower_hit;
    logic [31:0]         rd_chain [N_SLAVES+1];
    logic                any_hit, sel_ready;
    logic                timer_clear, timer_en, timer_expired;

    assign bus.s_addr  = bus.m_addr;
    assign bus.s_wdata = bus.m_wdata;
    assign bus.s_wstrb = bus.m_wstrb;

    // lower_hit[i] is set when any lower-indexed slave matched, giving
    // lowest-index priority on overlapping windows.
    assign lower_hit[0] = 1'b0;
    assign rd_chain[0]  = '0;

    for (genvar i = 0; i < N_SLAVES; i++) begin : g_slave
        assign hit[i]         = ((bus.m_addr & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32]);
        assign onehot[i]      = hit[i] & ~lower_hit[i];
        assign lower_hit[i+1] = lower_hit[i] | hit[i];
        assign rd_chain[i+1]  = rd_chain[i] | (sel_q[i] ? bus.s_rdata[32*i +: 32] : 32'h0);
    end

    assign any_hit   = lower_hit[N_SLAVES];
    assign sel_ready = |(bus.s_ready & sel_q);

    mem_bus_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (timer_clear),
        .enable  (timer_en),
        .expired (timer_expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            sel_q     <= '0;
            err_addr  <= '0;
            err_count <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            if (state_q == ST_ERR) begin
                err_addr <= bus.m_addr;
                if (err_count != 8'hFF) begin
                    err_count <= err_count + 8'd1;
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        bus.m_ready = 1'b0;
        bus.m_rdata = '0;
        bus.s_sel   = '0;
        err_irq     = 1'b0;
        timer_clear = 1'b0;
        timer_en    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                timer_clear = 1'b1;
                if (bus.m_valid) begin
                    if (any_hit) begin
                        sel_d   = onehot;
                        state_d = ST_ACTIVE;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_ACTIVE: begin
                if (!bus.m_valid) begin
                    state_d = ST_IDLE;
                end else begin
                    // select drops in the expiry cycle, but a late ready still completes
                    if (!timer_expired) begin
                        bus.s_sel = sel_q;
                        timer_en  = 1'b1;
                    end
                    if (sel_ready) begin
                        bus.m_ready = 1'b1;
                        bus.m_rdata = rd_chain[N_SLAVES];
                        state_d     = ST_DONE;
                    end else if (timer_expired) begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_ERR: begin
                bus.m_ready = 1'b1;
                bus.m_rdata = ERR_RDATA;
                err_irq     = 1'b1;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_mem_bus_xbar.sv
// Self-checking bench for mem_bus_xbar: vector table plus hand sequences for
// timeout, ignored foreign ready, abort, error saturation and async reset.
module tb_mem_bus_xbar;
    import mem_bus_xbar_pkg::*;

    localparam int N = 4;
    localparam logic [N*32-1:0] BASES = {SYSTICK_BASE, LED_BASE, SRAM_BASE, FLASH_BASE};
    localparam logic [N*32-1:0] MASKS = {SYSTICK_MASK, LED_MASK, SRAM_MASK, FLASH_MASK};
    localparam logic [31:0] RD_FLASH   = 32'hF1A5_F1A5;
    localparam logic [31:0] RD_SRAM    = 32'h1234_5678;
    localparam logic [31:0] RD_LED     = 32'h0000_00AA;
    localparam logic [31:0] RD_SYSTICK = 32'h5157_1C00;
    localparam logic [31:0] DEAD       = 32'hDEAD_BEEF;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [3:0]  sel;
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } vec_t;

    logic        clk;
    logic        reset_n;
    logic        err_irq;
    logic [31:0] err_addr;
    logic [7:0]  err_count;

    mem_bus_xbar_if #(.N_SLAVES(N)) bus ();

    mem_bus_xbar #(
        .N_SLAVES       (N),
        .SLAVE_BASE     (BASES),
        .SLAVE_MASK     (MASKS),
        .TIMEOUT_CYCLES (8),
        .ERR_RDATA      (DEAD)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .err_irq   (err_irq),
        .err_addr  (err_addr),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int       checks = 0;
    int       failures = 0;
    vec_t     sb[$];
    vec_t     vecs[10];
    int       lat[N];
    int       sel_cnt[N];
    logic [3:0] force_ready;
    int       mon_cyc, mon_sel_cyc, last_sel_cyc;
    logic [3:0] mon_sel_seen;
    logic [7:0] exp_err_cnt;
    logic [31:0] exp_err_addr;

    // slave models: ready after lat[i] cycles of select; force_ready overrides
    assign bus.s_rdata = {RD_SYSTICK, RD_LED, RD_SRAM, RD_FLASH};

    always_comb begin
        bus.s_ready = '0;
        for (int i = 0; i < N; i++) begin
            bus.s_ready[i] = force_ready[i] |
                             (bus.s_sel[i] && lat[i] >= 0 && sel_cnt[i] >= lat[i]);
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            sel_cnt[i] <= bus.s_sel[i] ? sel_cnt[i] + 1 : 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic monitor_step();
        vec_t e;
        if (bus.m_ready && (!bus.m_valid || sb.size() == 0)) begin
            checks++;
            failures++;
            $display("FAIL unexpected_m_ready got=1 want=0");
        end
        if (!reset_n || !bus.m_valid) begin
            mon_cyc      = 0;
            mon_sel_cyc  = 0;
            mon_sel_seen = '0;
        end else begin
            mon_cyc++;
            mon_sel_seen |= bus.s_sel;
            if (bus.s_sel != '0) mon_sel_cyc++;
            if (bus.m_ready && sb.size() != 0) begin
                e = sb.pop_front();
                chk("m_rdata", bus.m_rdata, e.rdata);
                chk("sel_seen", 32'(mon_sel_seen), 32'(e.sel));
                chk("err_irq", 32'(err_irq), 32'(e.err));
                chk("latency", 32'(mon_cyc), 32'(e.lat));
                chk("s_wdata", bus.s_wdata, e.wdata);
                chk("s_wstrb", 32'(bus.s_wstrb), 32'(e.wstrb));
                last_sel_cyc = mon_sel_cyc;
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            monitor_step();
        end
    end

    task automatic xact(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                        input logic [3:0] esel, input logic [31:0] erd, input logic eerr,
                        input int elat);
        vec_t e;
        bit   done;
        int   n;
        e = '{a, wd, ws, esel, erd, eerr, elat};
        sb.push_back(e);
        if (eerr) begin
            if (exp_err_cnt != 8'hFF) exp_err_cnt = exp_err_cnt + 8'd1;
            exp_err_addr = a;
        end
        @(posedge clk);
        #1;
        bus.m_valid = 1'b1;
        bus.m_addr  = a;
        bus.m_wdata = wd;
        bus.m_wstrb = ws;
        done = 1'b0;
        n = 0;
        while (!done && n < 64) begin
            @(negedge clk);
            n++;
            if (bus.m_ready) done = 1'b1;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL xact_timeout addr=%h got=no_m_ready want=m_ready", a);
            sb.delete();
        end
        @(posedge clk);
        #1;
        bus.m_valid = 1'b0;
    endtask

    initial begin
        reset_n      = 1'b0;
        bus.m_valid  = 1'b0;
        bus.m_addr   = '0;
        bus.m_wdata  = '0;
        bus.m_wstrb  = '0;
        force_ready  = '0;
        exp_err_cnt  = '0;
        exp_err_addr = '0;
        lat[0] = 0; lat[1] = 1; lat[2] = 0; lat[3] = 2;

        //          addr          wdata         ws     sel      rdata       err   lat
        vecs[0] = '{32'h0002_0010, 32'h0,        4'h0, 4'b0010, RD_SRAM,    1'b0, 3};
        vecs[1] = '{32'h8000_0000, 32'h3F,       4'hF, 4'b0100, RD_LED,     1'b0, 2};
        vecs[2] = '{32'h4000_0000, 32'h0,        4'h0, 4'b0000, DEAD,       1'b1, 2};
        vecs[3] = '{32'h0000_1000, 32'h0,        4'h0, 4'b0001, RD_FLASH,   1'b0, 2};
        vecs[4] = '{32'h0001_FFFC, 32'h0,        4'h0, 4'b0001, RD_FLASH,   1'b0, 2};
        vecs[5] = '{32'h0002_2000, 32'h0,        4'h0, 4'b0000, DEAD,       1'b1, 2};
        vecs[6] = '{32'h8000_010C, 32'h0,        4'h0, 4'b1000, RD_SYSTICK, 1'b0, 4};
        vecs[7] = '{32'h8000_0110, 32'h0,        4'h0, 4'b0000, DEAD,       1'b1, 2};
        vecs[8] = '{32'h0002_1FFC, 32'hCAFE_0001, 4'h3, 4'b0010, RD_SRAM,   1'b0, 3};
        vecs[9] = '{32'h8000_0004, 32'h55,       4'h1, 4'b0000, DEAD,       1'b1, 2};

        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("rst_m_ready", 32'(bus.m_ready), 32'h0);
        chk("rst_m_rdata", bus.m_rdata, 32'h0);
        chk("rst_s_sel", 32'(bus.s_sel), 32'h0);
        chk("rst_err_irq", 32'(err_irq), 32'h0);
        chk("rst_err_addr", err_addr, 32'h0);
        chk("rst_err_count", 32'(err_count), 32'h0);

        for (int i = 0; i < 10; i++) begin
            xact(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, vecs[i].sel,
                 vecs[i].rdata, vecs[i].err, vecs[i].lat);
        end
        chk("tbl_err_count", 32'(err_count), 32'(exp_err_cnt));
        chk("tbl_err_addr", err_addr, exp_err_addr);

        // systick never ready: 8 selected cycles, one expiry cycle, then error
        lat[3] = -1;
        xact(32'h8000_0100, 32'h0, 4'h0, 4'b1000, DEAD, 1'b1, 11);
        chk("to_sel_cycles", 32'(last_sel_cyc), 32'd8);
        chk("to_err_addr", err_addr, 32'h8000_0100);
        chk("to_err_count", 32'(err_count), 32'(exp_err_cnt));

        // ready arriving in the expiry cycle wins over the timeout
        fork
            xact(32'h8000_0104, 32'h0, 4'h0, 4'b1000, RD_SYSTICK, 1'b0, 10);
            begin
                repeat (10) @(posedge clk);
                #1 force_ready = 4'b1000;
                @(posedge clk);
                #1 force_ready = 4'b0000;
            end
        join
        chk("edge_err_count", 32'(err_count), 32'(exp_err_cnt));
        lat[3] = 2;

        // foreign ready from flash must not complete an sram access
        force_ready = 4'b0001;
        xact(32'h0002_0040, 32'h0, 4'h0, 4'b0010, RD_SRAM, 1'b0, 3);
        force_ready = 4'b0000;

        // master drops m_valid mid-access: silent abort
        lat[1] = -1;
        @(posedge clk);
        #1;
        bus.m_valid = 1'b1;
        bus.m_addr  = 32'h0002_0080;
        bus.m_wstrb = 4'h0;
        repeat (3) @(negedge clk);
        chk("abort_sel_before", 32'(bus.s_sel), 32'b0010);
        @(posedge clk);
        #1 bus.m_valid = 1'b0;
        @(negedge clk);
        chk("abort_sel_after", 32'(bus.s_sel), 32'h0);
        chk("abort_err_irq", 32'(err_irq), 32'h0);
        repeat (3) @(negedge clk);
        chk("abort_err_count", 32'(err_count), 32'(exp_err_cnt));
        lat[1] = 1;
        xact(32'h0002_0010, 32'h0, 4'h0, 4'b0010, RD_SRAM, 1'b0, 3);

        for (int i = 0; i < 300; i++) begin
            xact(32'h4000_0000 + 32'(i * 16), 32'h0, 4'h0, 4'b0000, DEAD, 1'b1, 2);
        end
        chk("sat_err_count", 32'(err_count), 32'hFF);
        chk("sat_err_addr", err_addr, exp_err_addr);

        // asynchronous reset in the middle of an access
        lat[1] = -1;
        @(posedge clk);
        #1;
        bus.m_valid = 1'b1;
        bus.m_addr  = 32'h0002_0100;
        repeat (3) @(negedge clk);
        chk("prerst_sel", 32'(bus.s_sel), 32'b0010);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_s_sel", 32'(bus.s_sel), 32'h0);
        chk("arst_m_ready", 32'(bus.m_ready), 32'h0);
        chk("arst_m_rdata", bus.m_rdata, 32'h0);
        chk("arst_err_irq", 32'(err_irq), 32'h0);
        chk("arst_err_addr", err_addr, 32'h0);
        chk("arst_err_count", 32'(err_count), 32'h0);
        bus.m_valid  = 1'b0;
        exp_err_cnt  = '0;
        exp_err_addr = '0;
        lat[1] = 1;
        @(posedge clk);
        #1 reset_n = 1'b1;
        xact(32'h0002_0010, 32'h0, 4'h0, 4'b0010, RD_SRAM, 1'b0, 3);
        xact(32'h9000_0000, 32'h0, 4'h0, 4'b0000, DEAD, 1'b1, 2);
        chk("post_err_count", 32'(err_count), 32'h1);
        chk("post_err_addr", err_addr, 32'h9000_0000);

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
